// File: rtl/sram_bus_arbiter_pkg.sv
// Shared constants for the SRAM bus arbiter: response tag IDs and the
// like-SRAM request bundle layout {wr, wen[3:0], addr[31:0], wdata[31:0]}.
package sram_bus_arbiter_pkg;

    // Tag stored per accepted request, identifying who must receive the response.
    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    // Width of one like-SRAM request bundle: wr + wen + addr + wdata.
    localparam int SRAM_REQ_W = 1 + 4 + 32 + 32;

    // Packs the request fields of a master into a single bundle.
    function automatic logic [SRAM_REQ_W-1:0] pack_req(
        input logic        wr,
        input logic [3:0]  wen,
        input logic [31:0] addr,
        input logic [31:0] wdata
    );
        return {wr, wen, addr, wdata};
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_tag_fifo.sv
// In-order 1-bit tag FIFO. One entry per accepted bus request; the head
// tells which master owns the next slave response. DEPTH must be a power
// of two so the pointers wrap naturally.
module sram_bus_arbiter_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic                     push_tag_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Guard both operations so a stray push when full or pop when empty is a no-op.
    always_comb begin
        do_push  = push_i && !full_o;
        do_pop   = pop_i && !empty_o;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards every outstanding tag.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Tag storage needs no reset: an entry is only read after it was written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_tag_i;
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one like-SRAM slave between the IF instruction port and the EXE
// data port. Data normally has priority; an instruction request that has
// lost STARVE_MAX cycles in a row is forced through. Every accepted request
// leaves a tag in an in-order FIFO so responses can be routed back.
//
// Handshake (all ports): a request transfers in a cycle where req and
// addr_ok are both high; the master holds req and payload until then.
// Each transfer is answered by exactly one data_ok, in issue order, in a
// later cycle than the transfer.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int STARVE_MAX  = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    // instruction master
    input  logic                               inst_req,
    input  logic                               inst_wr,
    input  logic [3:0]                         inst_wen,
    input  logic [31:0]                        inst_addr,
    input  logic [31:0]                        inst_wdata,
    output logic                               inst_addr_ok,
    output logic                               inst_data_ok,
    output logic [31:0]                        inst_rdata,
    // data master
    input  logic                               data_req,
    input  logic                               data_wr,
    input  logic [3:0]                         data_wen,
    input  logic [31:0]                        data_addr,
    input  logic [31:0]                        data_wdata,
    output logic                               data_addr_ok,
    output logic                               data_data_ok,
    output logic [31:0]                        data_rdata,
    // shared slave
    output logic                               bus_req,
    output logic                               bus_wr,
    output logic [3:0]                         bus_wen,
    output logic [31:0]                        bus_addr,
    output logic [31:0]                        bus_wdata,
    input  logic                               bus_addr_ok,
    input  logic                               bus_data_ok,
    input  logic [31:0]                        bus_rdata,
    // status and observability
    output logic                               resp_err,
    output logic [$clog2(STARVE_MAX+1)-1:0]    dbg_starve_cnt,
    output logic [$clog2(OUTSTANDING):0]       dbg_fifo_count
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    logic [SC_W-1:0]       starve_q, starve_d;
    logic                  resp_err_q, resp_err_d;

    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_head;

    logic                  can_issue;
    logic                  inst_forced;
    logic                  grant_data;
    logic                  grant_inst;
    logic                  push;
    logic                  pop;

    logic [SRAM_REQ_W-1:0] inst_bundle;
    logic [SRAM_REQ_W-1:0] data_bundle;
    logic [SRAM_REQ_W-1:0] bus_bundle;

    assign inst_bundle = pack_req(inst_wr, inst_wen, inst_addr, inst_wdata);
    assign data_bundle = pack_req(data_wr, data_wen, data_addr, data_wdata);
    assign {bus_wr, bus_wen, bus_addr, bus_wdata} = bus_bundle;

    // Grant and forwarding: data wins unless the instruction port is starved.
    // A full FIFO blocks issue from the registered count even if a response
    // pops in the same cycle.
    always_comb begin
        can_issue    = !fifo_full;
        inst_forced  = inst_req && (starve_q == SC_W'(STARVE_MAX));
        grant_data   = data_req && !inst_forced;
        grant_inst   = inst_req && !grant_data;
        bus_req      = can_issue && (grant_data || grant_inst);
        // With no grant the data master's fields are presented.
        bus_bundle   = grant_inst ? inst_bundle : data_bundle;
        data_addr_ok = bus_addr_ok && bus_req && grant_data;
        inst_addr_ok = bus_addr_ok && bus_req && grant_inst;
        push         = bus_req && bus_addr_ok;
        pop          = bus_data_ok && !fifo_empty;
    end

    // Response routing from the FIFO head; read data is shared by both masters.
    always_comb begin
        inst_data_ok = bus_data_ok && !fifo_empty && (fifo_head == ID_INST);
        data_data_ok = bus_data_ok && !fifo_empty && (fifo_head == ID_DATA);
        inst_rdata   = bus_rdata;
        data_rdata   = bus_rdata;
    end

    // Starvation count and the sticky orphan-response flag.
    always_comb begin
        starve_d = starve_q;
        if (!inst_req || inst_addr_ok) begin
            starve_d = '0;
        end else if (starve_q != SC_W'(STARVE_MAX)) begin
            starve_d = starve_q + SC_W'(1);
        end
        resp_err_d = resp_err_q || (bus_data_ok && fifo_empty);
    end

    // State registers for the arbiter itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_q   <= '0;
            resp_err_q <= 1'b0;
        end else begin
            starve_q   <= starve_d;
            resp_err_q <= resp_err_d;
        end
    end

    assign resp_err       = resp_err_q;
    assign dbg_starve_cnt = starve_q;

    sram_bus_arbiter_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .push_tag_i (grant_data ? ID_DATA : ID_INST),
        .pop_i      (pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head),
        .count_o    (dbg_fifo_count)
    );

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: bench-side masters and slave, a queue-based
// reference model compared every cycle, per-master response scoreboards,
// and directed scenarios with literal expectations followed by random traffic.
module tb_sram_bus_arbiter;
  import sram_bus_arbiter_pkg::*;

  localparam int OUTSTANDING = 4;
  localparam int STARVE_MAX  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        inst_req = 0, inst_wr = 0;
  logic [3:0]  inst_wen = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req = 0, data_wr = 0;
  logic [3:0]  data_wen = 0;
  logic [31:0] data_addr = 0, data_wdata = 0;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [3:0]  bus_wen;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok = 0, bus_data_ok = 0;
  logic [31:0] bus_rdata = 0;
  logic        resp_err;
  logic [3:0]  dbg_starve_cnt;
  logic [2:0]  dbg_fifo_count;

  sram_bus_arbiter #(.OUTSTANDING(OUTSTANDING), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_wen(inst_wen),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wen(bus_wen),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .resp_err(resp_err), .dbg_starve_cnt(dbg_starve_cnt), .dbg_fifo_count(dbg_fifo_count)
  );

  // ---------------- counters and check helper ----------------
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // slave response data derived from the address it saw
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hA5A5_5A5A;
  endfunction

  // ---------------- stimulus knobs and bench-side agents ----------------
  int unsigned i_rate = 0, d_rate = 0, aok_rate = 0, dok_rate = 0, wr_rate = 0;
  int unsigned lat = 1;
  int          i_budget = 0, d_budget = 0;
  logic        rst_knob = 1'b1;
  logic        spurious = 1'b0;
  logic        i_pend = 0, d_pend = 0;
  logic [31:0] i_next = 32'h0000_1000, d_next = 32'h0000_8000;
  int          cyc = 0;

  logic [31:0] slave_d[$];
  int          slave_t[$];
  logic [31:0] inst_exp_q[$];
  logic [31:0] data_exp_q[$];

  // observed-event statistics used by directed checks
  int          n_inst_acc, n_data_acc, n_inst_resp, n_data_resp;
  logic [31:0] acc_addr[$];
  logic [31:0] resp_i[$];
  logic [31:0] resp_d[$];
  logic        first_inst_seen, capture_next;
  int          data_before_inst, starve_after;

  task automatic clear_stats();
    n_inst_acc = 0; n_data_acc = 0; n_inst_resp = 0; n_data_resp = 0;
    acc_addr.delete(); resp_i.delete(); resp_d.delete();
    first_inst_seen = 0; capture_next = 0; data_before_inst = -1; starve_after = -1;
  endtask

  // drive all DUT inputs for one cycle (called just after the rising edge)
  task automatic drive();
    reset = rst_knob;
    if (rst_knob) begin
      inst_req = 0; data_req = 0; bus_addr_ok = 0; bus_data_ok = 0;
      bus_rdata = $urandom;
      return;
    end
    if (!i_pend && i_budget > 0 && $urandom_range(0, 99) < i_rate) begin
      i_pend = 1; i_budget--;
      inst_addr = i_next; i_next += 32'd4;
      inst_wr = 0; inst_wen = 4'h0; inst_wdata = $urandom;
    end
    if (!d_pend && d_budget > 0 && $urandom_range(0, 99) < d_rate) begin
      d_pend = 1; d_budget--;
      data_addr = d_next; d_next += 32'd4;
      data_wr = ($urandom_range(0, 99) < wr_rate);
      data_wen = data_wr ? 4'($urandom_range(1, 15)) : 4'h0;
      data_wdata = $urandom;
    end
    inst_req = i_pend;
    data_req = d_pend;
    bus_addr_ok = ($urandom_range(0, 99) < aok_rate);
    if (spurious) begin
      bus_data_ok = 1; bus_rdata = $urandom; spurious = 0;
    end else if (slave_d.size() > 0 && cyc >= slave_t[0] && $urandom_range(0, 99) < dok_rate) begin
      bus_data_ok = 1; bus_rdata = slave_d[0];
    end else begin
      bus_data_ok = 0; bus_rdata = $urandom;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- reference model and compare (every falling edge) ----------------
  logic m_tag_q[$];
  int   m_starve = 0;
  logic m_err = 0;

  always @(negedge clk) begin : compare
    logic full, empty, head, gd, gi, e_req, e_iaok, e_daok, e_idok, e_ddok;
    logic        e_wr;
    logic [3:0]  e_wen;
    logic [31:0] e_addr, e_wdata;
    full  = (m_tag_q.size() == OUTSTANDING);
    empty = (m_tag_q.size() == 0);
    head  = empty ? ID_INST : m_tag_q[0];
    gd    = data_req && !(inst_req && m_starve == STARVE_MAX);
    gi    = inst_req && !gd;
    e_req  = !full && (gd || gi);
    e_iaok = bus_addr_ok && e_req && gi;
    e_daok = bus_addr_ok && e_req && gd;
    e_idok = bus_data_ok && !empty && (head == ID_INST);
    e_ddok = bus_data_ok && !empty && (head == ID_DATA);
    e_wr    = gi ? inst_wr    : data_wr;
    e_wen   = gi ? inst_wen   : data_wen;
    e_addr  = gi ? inst_addr  : data_addr;
    e_wdata = gi ? inst_wdata : data_wdata;

    chk("bus_req",      32'(bus_req),      32'(e_req));
    chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_iaok));
    chk("data_addr_ok", 32'(data_addr_ok), 32'(e_daok));
    chk("inst_data_ok", 32'(inst_data_ok), 32'(e_idok));
    chk("data_data_ok", 32'(data_data_ok), 32'(e_ddok));
    chk("bus_wr",       32'(bus_wr),       32'(e_wr));
    chk("bus_wen",      32'(bus_wen),      32'(e_wen));
    chk("bus_addr",     bus_addr,          e_addr);
    chk("bus_wdata",    bus_wdata,         e_wdata);
    chk("inst_rdata",   inst_rdata,        bus_rdata);
    chk("data_rdata",   data_rdata,        bus_rdata);
    chk("resp_err",     32'(resp_err),     32'(m_err));
    chk("starve_cnt",   32'(dbg_starve_cnt), 32'(m_starve));
    chk("fifo_count",   32'(dbg_fifo_count), 32'(m_tag_q.size()));

    // statistics from the DUT's own outputs
    if (capture_next) begin
      starve_after = int'(dbg_starve_cnt);
      capture_next = 0;
    end
    if (inst_addr_ok) begin
      if (!first_inst_seen) begin
        first_inst_seen = 1; data_before_inst = n_data_acc; capture_next = 1;
      end
      n_inst_acc++;
    end
    if (data_addr_ok) begin
      n_data_acc++; acc_addr.push_back(bus_addr);
    end

    // per-master response scoreboards
    if (inst_data_ok) begin
      n_inst_resp++; resp_i.push_back(inst_rdata);
      if (inst_exp_q.size() == 0) chk("inst_resp_unexpected", 32'd1, 32'd0);
      else chk("inst_resp_data", inst_rdata, inst_exp_q.pop_front());
    end
    if (data_data_ok) begin
      n_data_resp++; resp_d.push_back(data_rdata);
      if (data_exp_q.size() == 0) chk("data_resp_unexpected", 32'd1, 32'd0);
      else chk("data_resp_data", data_rdata, data_exp_q.pop_front());
    end

    if (reset) begin
      m_tag_q.delete(); m_starve = 0; m_err = 0;
      slave_d.delete(); slave_t.delete();
      inst_exp_q.delete(); data_exp_q.delete();
      i_pend = 0; d_pend = 0;
    end else begin
      // slave side: consume a response, record a newly accepted request
      if (bus_data_ok && slave_d.size() > 0) begin
        void'(slave_d.pop_front()); void'(slave_t.pop_front());
      end
      if (e_req && bus_addr_ok) begin
        slave_d.push_back(slave_data(bus_addr));
        slave_t.push_back(cyc + int'(lat));
      end
      // master side: a transfer ends the hold and creates an expectation
      if (e_iaok) begin
        i_pend = 0; inst_exp_q.push_back(slave_data(inst_addr));
      end
      if (e_daok) begin
        d_pend = 0; data_exp_q.push_back(slave_data(data_addr));
      end
      // model state advance
      if (bus_data_ok && empty) m_err = 1;
      if (bus_data_ok && !empty) void'(m_tag_q.pop_front());
      if (e_req && bus_addr_ok) m_tag_q.push_back(gd ? ID_DATA : ID_INST);
      if (!inst_req || e_iaok) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
    end
    cyc++;
  end

  task automatic quiet_knobs();
    i_rate = 0; d_rate = 0; aok_rate = 0; dok_rate = 0; wr_rate = 0;
    i_budget = 0; d_budget = 0; lat = 1;
  endtask

  task automatic do_reset();
    rst_knob = 1; step(); rst_knob = 0;
  endtask

  // ---------------- directed scenarios then random traffic ----------------
  initial begin
    clear_stats();
    quiet_knobs();
    rst_knob = 1;
    steps(3);
    rst_knob = 0;
    step();
    chk("rst_bus_req",   32'(bus_req), 32'd0);
    chk("rst_addr_ok",   32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk("rst_data_ok",   32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("rst_resp_err",  32'(resp_err), 32'd0);
    chk("rst_count",     32'(dbg_fifo_count), 32'd0);
    chk("rst_starve",    32'(dbg_starve_cnt), 32'd0);

    // data-only reads, two-cycle slave
    clear_stats();
    d_next = 32'h100; d_rate = 100; d_budget = 4; aok_rate = 100; dok_rate = 100; lat = 2;
    steps(12);
    chk("t1_data_acc",  32'(n_data_acc), 32'd4);
    chk("t1_data_resp", 32'(n_data_resp), 32'd4);
    chk("t1_inst_resp", 32'(n_inst_resp), 32'd0);
    chk("t1_addr0", (acc_addr.size() > 0) ? acc_addr[0] : 32'hX, 32'h100);
    chk("t1_addr3", (acc_addr.size() > 3) ? acc_addr[3] : 32'hX, 32'h10C);

    // starvation forcing
    quiet_knobs(); do_reset(); clear_stats();
    i_rate = 100; i_budget = 2; d_rate = 100; d_budget = 12;
    aok_rate = 100; dok_rate = 100; lat = 1;
    steps(18);
    chk("t2_data_wins",    32'(data_before_inst), 32'd8);
    chk("t2_starve_after", 32'(starve_after), 32'd0);
    chk("t2_inst_acc",     32'(n_inst_acc), 32'd2);
    chk("t2_data_acc",     32'(n_data_acc), 32'd12);

    // full FIFO blocks issue
    quiet_knobs(); do_reset(); clear_stats();
    d_rate = 100; d_budget = 5; aok_rate = 100; dok_rate = 0; lat = 1;
    steps(6);
    chk("t3_acc4",   32'(n_data_acc), 32'd4);
    chk("t3_count4", 32'(dbg_fifo_count), 32'd4);
    chk("t3_blocked", 32'(bus_req), 32'd0);
    dok_rate = 100;
    step();
    chk("t3_pop",        32'(data_data_ok), 32'd1);
    chk("t3_still_full", 32'(bus_req), 32'd0);
    step();
    chk("t3_fifth",     32'(data_addr_ok), 32'd1);
    chk("t3_acc5",      32'(n_data_acc), 32'd5);
    steps(8);

    // interleaved routing
    quiet_knobs(); do_reset(); clear_stats();
    aok_rate = 100; dok_rate = 0; lat = 1;
    i_next = 32'h2000; d_next = 32'h3000;
    i_rate = 100; d_rate = 100;
    i_budget = 1; steps(2);
    d_budget = 1; steps(2);
    i_budget = 1; steps(2);
    chk("t4_inst_acc", 32'(n_inst_acc), 32'd2);
    chk("t4_data_acc", 32'(n_data_acc), 32'd1);
    dok_rate = 100;
    steps(5);
    chk("t4_inst_resp", 32'(resp_i.size()), 32'd2);
    chk("t4_data_resp", 32'(resp_d.size()), 32'd1);
    chk("t4_inst_A", (resp_i.size() > 0) ? resp_i[0] : 32'hX, 32'h85A5_5A5A);
    chk("t4_data_B", (resp_d.size() > 0) ? resp_d[0] : 32'hX, 32'h95A5_5A5A);
    chk("t4_inst_C", (resp_i.size() > 1) ? resp_i[1] : 32'hX, 32'h85A1_5A5A);

    // orphan response
    quiet_knobs(); do_reset(); clear_stats();
    steps(2);
    spurious = 1;
    step();
    chk("t5_no_inst_ok", 32'(inst_data_ok), 32'd0);
    chk("t5_no_data_ok", 32'(data_data_ok), 32'd0);
    step();
    chk("t5_err_set", 32'(resp_err), 32'd1);
    chk("t5_count0",  32'(dbg_fifo_count), 32'd0);
    steps(3);
    chk("t5_err_sticky", 32'(resp_err), 32'd1);

    // reset with tags outstanding and a starving instruction port
    clear_stats();
    d_rate = 100; d_budget = 3; aok_rate = 100; dok_rate = 0;
    steps(4);
    chk("t6_count3", 32'(dbg_fifo_count), 32'd3);
    aok_rate = 0; i_rate = 100; i_budget = 1;
    steps(3);
    chk("t6_starving", 32'(dbg_starve_cnt), 32'd2);
    do_reset();
    d_budget = 1; aok_rate = 100; dok_rate = 100;
    step();
    chk("t6_count0",  32'(dbg_fifo_count), 32'd0);
    chk("t6_err0",    32'(resp_err), 32'd0);
    chk("t6_starve0", 32'(dbg_starve_cnt), 32'd0);
    chk("t6_bus_req", 32'(bus_req), 32'd1);
    chk("t6_accept",  32'(data_addr_ok), 32'd1);
    steps(4);

    // random traffic
    for (int blk = 0; blk < 10; blk++) begin
      i_rate = $urandom_range(0, 100); d_rate = $urandom_range(0, 100);
      aok_rate = $urandom_range(20, 100); dok_rate = $urandom_range(20, 100);
      lat = $urandom_range(1, 4); wr_rate = 30;
      i_budget = 1000000; d_budget = 1000000;
      i_next = $urandom & 32'hFFFF_FFFC; d_next = $urandom & 32'hFFFF_FFFC;
      for (int k = 0; k < 300; k++) begin
        rst_knob = ($urandom_range(0, 499) == 0);
        step();
      end
      rst_knob = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
